// File: rtl/i2c_target.sv
// i2c_target: I2C target with a 4-byte register file; optional input glitch filter via I2C_TARGET_GLITCH_FILTER_EN
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h3C
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [31:0] Regs,
  output logic        WriteStrobe,
  output logic        Busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, WRITE, WR_ACK, READ, RD_ACK, IGNORE} state_t;
  state_t state;
  logic [1:0] scl_sy, sda_sy;
  logic scl, sda, scl_d, sda_d, oe, rw;
  logic [3:0] cnt;
  logic [6:0] sh;
  logic [1:0] ptr;
  logic [7:0] rx, cur;
  logic scl_rise, scl_fall, start, stop;
  // two-flop synchronizers, idle-high after reset
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], SCL};
      sda_sy <= {sda_sy[0], SDA};
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic scl_f, sda_f;
  // 3-sample majority vote over the synchronized lines, registered
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sy[1]};
      sda_h <= {sda_h[0], sda_sy[1]};
      scl_f <= (scl_sy[1] & scl_h[0]) | (scl_sy[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
      sda_f <= (sda_sy[1] & sda_h[0]) | (sda_sy[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
    end
  assign scl = scl_f;
  assign sda = sda_f;
`else
  assign scl = scl_sy[1];
  assign sda = sda_sy[1];
`endif
  // previous line values for edge and START/STOP detection
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl;
      sda_d <= sda;
    end
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop = scl & scl_d & ~sda_d & sda;
  assign rx = {sh, sda};
  assign cur = Regs[{ptr, 3'b000} +: 8];
  assign SDA = oe ? 1'b0 : 1'bz;
  // protocol FSM; SDA only changes after a falling SCL edge
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      sh <= 7'd0;
      ptr <= 2'd0;
      rw <= 1'b0;
      oe <= 1'b0;
      Regs <= 32'd0;
      WriteStrobe <= 1'b0;
      Busy <= 1'b0;
    end else begin
      WriteStrobe <= 1'b0;
      if (start) begin
        state <= ADDR;
        cnt <= 4'd0;
        Busy <= 1'b0;
        oe <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        cnt <= 4'd0;
        Busy <= 1'b0;
        oe <= 1'b0;
      end else case (state)
        ADDR: if (scl_rise) begin
          sh <= rx[6:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt <= 4'd0;
            if (rx[7:1] == ADDRESS) begin
              state <= ADDR_ACK;
              rw <= rx[0];
              Busy <= 1'b1;
            end else state <= IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (cnt == 4'd0) begin
            oe <= 1'b1;
            cnt <= 4'd1;
          end else begin
            cnt <= 4'd0;
            if (rw) begin
              state <= READ;
              sh <= cur[6:0];
              oe <= ~cur[7];
            end else begin
              state <= PTR;
              oe <= 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          sh <= rx[6:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt <= 4'd0;
            ptr <= rx[1:0];
            state <= WR_ACK;
          end
        end
        WRITE: if (scl_rise) begin
          sh <= rx[6:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt <= 4'd0;
            Regs[{ptr, 3'b000} +: 8] <= rx;
            WriteStrobe <= 1'b1;
            ptr <= ptr + 2'd1;
            state <= WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (cnt == 4'd0) begin
            oe <= 1'b1;
            cnt <= 4'd1;
          end else begin
            oe <= 1'b0;
            cnt <= 4'd0;
            state <= WRITE;
          end
        end
        READ: if (scl_rise) cnt <= cnt + 4'd1;
        else if (scl_fall) begin
          if (cnt == 4'd8) begin
            oe <= 1'b0;
            cnt <= 4'd0;
            ptr <= ptr + 2'd1;
            state <= RD_ACK;
          end else begin
            sh <= {sh[5:0], 1'b0};
            oe <= ~sh[6];
          end
        end
        RD_ACK: if (scl_rise) begin
          if (sda) state <= IGNORE;
          else cnt <= 4'd1;
        end else if (scl_fall && cnt == 4'd1) begin
          cnt <= 4'd0;
          state <= READ;
          sh <= cur[6:0];
          oe <= ~cur[7];
        end
        default: oe <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level checks of i2c_target (glitch case only with I2C_TARGET_GLITCH_FILTER_EN)
module tb_i2c_target;
  localparam int Q = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  wire sda_bus;
  logic [31:0] regs;
  logic ws, busy;
  int checks = 0;
  int errors = 0;
  int ws_cnt = 0;
  int busy_cnt = 0;
  int ws0, busy0;
  logic a;
  logic [7:0] d;
  pullup (sda_bus);
  assign sda_bus = sda_drv ? 1'bz : 1'b0;
  i2c_target dut (
    .Clock(clk),
    .Reset(rst),
    .SCL(scl_drv),
    .SDA(sda_bus),
    .Regs(regs),
    .WriteStrobe(ws),
    .Busy(busy)
  );
  always #5 clk = ~clk;
  // tallies of strobe pulses and busy cycles
  always @(posedge clk) begin
    if (ws) ws_cnt = ws_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic start_c();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask
  task automatic stop_c();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask
  task automatic bit_w(input logic b);
    sda_drv = b; #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask
  task automatic bit_r(output logic b);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_drv = 1'b0; #Q;
  endtask
  task automatic byte_w(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    bit_r(ack);
  endtask
  task automatic byte_r(output logic [7:0] v, input logic nack);
    for (int i = 7; i >= 0; i--) bit_r(v[i]);
    bit_w(nack);
  endtask
  initial begin
    #20;
    chk("rst_regs", regs, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ws", {31'd0, ws}, 32'd0);
    chk("rst_sda", {31'd0, sda_bus}, 32'd1);
    rst = 1'b0; #Q;
    ws0 = ws_cnt;
    start_c();
    byte_w(8'h78, a); chk("w1_addr_ack", {31'd0, a}, 32'd0);
    byte_w(8'h01, a); chk("w1_ptr_ack", {31'd0, a}, 32'd0);
    byte_w(8'hAA, a); chk("w1_d0_ack", {31'd0, a}, 32'd0);
    byte_w(8'h55, a); chk("w1_d1_ack", {31'd0, a}, 32'd0);
    chk("w1_busy", {31'd0, busy}, 32'd1);
    stop_c(); #Q;
    chk("w1_regs", regs, 32'h0055AA00);
    chk("w1_ws", ws_cnt - ws0, 32'd2);
    chk("w1_ptr", {30'd0, dut.ptr}, 32'd3);
    chk("w1_busy_off", {31'd0, busy}, 32'd0);
    ws0 = ws_cnt;
    start_c();
    byte_w(8'h78, a);
    byte_w(8'h03, a);
    byte_w(8'hC3, a);
    byte_w(8'h5A, a); chk("w2_wrap_ack", {31'd0, a}, 32'd0);
    stop_c(); #Q;
    chk("w2_regs", regs, 32'hC355AA5A);
    chk("w2_ws", ws_cnt - ws0, 32'd2);
    start_c();
    byte_w(8'h78, a);
    byte_w(8'hFF, a); chk("r_ptr_ack", {31'd0, a}, 32'd0);
    start_c();
    byte_w(8'h79, a); chk("r_addr_ack", {31'd0, a}, 32'd0);
    byte_r(d, 1'b0); chk("r_byte0", {24'd0, d}, 32'hC3);
    byte_r(d, 1'b1); chk("r_byte1", {24'd0, d}, 32'h5A);
    #Q;
    chk("r_sda_rel", {31'd0, sda_bus}, 32'd1);
    stop_c(); #Q;
    busy0 = busy_cnt;
    start_c();
    byte_w(8'h7A, a); chk("nm_addr_nack", {31'd0, a}, 32'd1);
    byte_w(8'h11, a); chk("nm_data_nack", {31'd0, a}, 32'd1);
    stop_c(); #Q;
    chk("nm_busy", busy_cnt - busy0, 32'd0);
    chk("nm_regs", regs, 32'hC355AA5A);
    start_c();
    byte_w(8'h78, a);
    byte_w(8'h00, a);
    bit_w(1'b0);
    bit_w(1'b0);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    rst = 1'b1; #1;
    chk("rst_mid_sda", {31'd0, sda_bus}, 32'd1);
    chk("rst_mid_regs", regs, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    #19 rst = 1'b0; #(Q-20);
    scl_drv = 1'b0; #Q;
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    bit_r(a); chk("rst_mid_nack", {31'd0, a}, 32'd1);
    stop_c(); #Q;
    chk("rst_mid_regs2", regs, 32'h0);
    start_c();
    byte_w(8'h78, a); chk("rst_next_ack", {31'd0, a}, 32'd0);
    byte_w(8'h02, a);
    byte_w(8'h9C, a); chk("rst_next_dack", {31'd0, a}, 32'd0);
    stop_c(); #Q;
    chk("rst_next_regs", regs, 32'h009C0000);
    ws0 = ws_cnt;
    start_c();
    byte_w(8'h78, a);
    byte_w(8'h01, a);
    bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b1);
    stop_c(); #Q;
    chk("sp_ws", ws_cnt - ws0, 32'd0);
    chk("sp_regs", regs, 32'h009C0000);
    chk("sp_busy", {31'd0, busy}, 32'd0);
    chk("sp_state", {28'd0, dut.state}, 32'd0);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    ws0 = ws_cnt;
    start_c();
    byte_w(8'h78, a);
    byte_w(8'h00, a);
    d = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      sda_drv = d[i]; #40;
      if (i == 5) begin
        scl_drv = 1'b1; #10;
        scl_drv = 1'b0; #50;
      end else #60;
      scl_drv = 1'b1; #(2*Q);
      scl_drv = 1'b0; #Q;
    end
    bit_r(a); chk("gl_ack", {31'd0, a}, 32'd0);
    stop_c(); #Q;
    chk("gl_regs", regs, 32'h009C00A5);
    chk("gl_ws", ws_cnt - ws0, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
